// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: turns one 256-bit dfp line read/write into a BURST_LEN x BEAT_W bmem burst.
// Optional BMEM_RADDR_CHECK_EN: read beats whose bmem_raddr differs from bmem_addr are dropped.
module cacheline_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   dfp_addr,
    input  logic                          dfp_read,
    input  logic                          dfp_write,
    input  logic [BEAT_W*BURST_LEN-1:0]   dfp_wdata,
    output logic [BEAT_W*BURST_LEN-1:0]   dfp_rdata,
    output logic                          dfp_resp,
    output logic [31:0]                   bmem_addr,
    output logic                          bmem_read,
    output logic                          bmem_write,
    output logic [BEAT_W-1:0]             bmem_wdata,
    input  logic                          bmem_ready,
    input  logic [31:0]                   bmem_raddr,
    input  logic [BEAT_W-1:0]             bmem_rdata,
    input  logic                          bmem_rvalid
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    beat;
    logic [26:0]         line_addr;
    logic [LINE_W-1:0]   line;
    logic                is_write;
    logic                last_beat;
    logic                beat_ok;

    assign bmem_addr = {line_addr, 5'b0};
    assign last_beat = (beat == CNT_W'(BURST_LEN - 1));

`ifdef BMEM_RADDR_CHECK_EN
    assign beat_ok = bmem_rvalid && (bmem_raddr == bmem_addr);

    logic unused_bits;
    assign unused_bits = ^dfp_addr[4:0];
`else
    assign beat_ok = bmem_rvalid;

    logic unused_bits;
    assign unused_bits = ^{dfp_addr[4:0], bmem_raddr};
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_next = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        dfp_rdata  = '0;
        case (state)
            IDLE: begin
                if (dfp_write)     state_next = WR_BURST;
                else if (dfp_read) state_next = RD_REQ;
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (beat_ok && last_beat) state_next = RESP;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_wdata = line[int'(beat)*BEAT_W +: BEAT_W];
                if (bmem_ready && last_beat) state_next = RESP;
            end
            RESP: begin
                dfp_resp   = 1'b1;
                if (!is_write) dfp_rdata = line;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            line_addr <= '0;
            is_write  <= 1'b0;
            // NOTE: the line buffer is a plain register and is cleared so dfp_rdata is defined from reset.
            line      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (dfp_write) begin
                        line_addr <= dfp_addr[31:5];
                        line      <= dfp_wdata;
                        is_write  <= 1'b1;
                    end else if (dfp_read) begin
                        line_addr <= dfp_addr[31:5];
                        is_write  <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (beat_ok) begin
                        line[int'(beat)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
`ifdef BMEM_RADDR_CHECK_EN
`ifndef SYNTHESIS
                    if (bmem_rvalid && !beat_ok)
                        $error("cacheline_adapter: beat raddr %h does not match %h", bmem_raddr, bmem_addr);
`endif
`endif
                end
                WR_BURST: begin
                    if (bmem_ready) beat <= last_beat ? '0 : beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
